// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode constants: datapath widths, queue depth default and the NOP encoding.
package fetch_queue_pkg;
    localparam int          FQ_DEPTH   = 4;
    localparam int          FQ_PC_W    = 64;
    localparam int          FQ_INSTR_W = 32;
    localparam logic [31:0] FQ_NOP     = 32'h00000013;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: push side, pop side, flush and occupancy.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int PC_W    = FQ_PC_W,
    parameter int INSTR_W = FQ_INSTR_W,
    parameter int DEPTH   = FQ_DEPTH
);
    logic                   in_valid;
    logic [PC_W-1:0]        in_pc;
    logic [INSTR_W-1:0]     in_instr;
    logic                   in_ready;
    logic                   out_valid;
    logic [PC_W-1:0]        out_pc;
    logic [INSTR_W-1:0]     out_instr;
    logic                   out_ready;
    logic                   flush;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output in_valid, in_pc, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry {pc, instr} FIFO, one cycle push-to-head latency, no bypass.
// Backpressure: in_ready drops only when full (registered count); flush empties the queue at the edge.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH   = FQ_DEPTH,
    parameter int PC_W    = FQ_PC_W,
    parameter int INSTR_W = FQ_INSTR_W
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic               not_empty;
    logic               not_full;

    assign not_empty = (count != '0);
    assign not_full  = (count != CNT_W'(DEPTH));

    // flush wins over both handshakes so a redirect never keeps a stale entry
    assign push = q.in_valid  && not_full  && !q.flush;
    assign pop  = not_empty   && q.out_ready && !q.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (q.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= q.in_pc;
            instr_mem[wr_ptr] <= q.in_instr;
        end
    end

    assign q.in_ready  = not_full;
    assign q.out_valid = not_empty;
    assign q.count     = count;
    assign q.out_pc    = not_empty ? pc_mem[rd_ptr]    : '0;
    assign q.out_instr = not_empty ? instr_mem[rd_ptr] : INSTR_W'(FQ_NOP);
endmodule
